// File: rtl/div_pkg.sv
// Shared types and constants for the pipelined restoring divider.
// The record widths are fixed here; the top-level N/TAG_W must match DIV_N/DIV_TAG_W.
package div_pkg;

    localparam int DIV_N      = 16;
    localparam int DIV_STAGES = 4;
    localparam int DIV_TAG_W  = 4;

    // One in-flight division as it travels through the iteration stages.
    // quo starts as |A| and is shifted left, so dividend bits leave the top
    // while quotient bits enter at the bottom.
    typedef struct packed {
        logic                 vld;
        logic [DIV_TAG_W-1:0] tag;
        logic                 q_neg;
        logic                 r_neg;
        logic                 div0;
        logic                 ovf;
        logic [DIV_N-1:0]     dvs;
        logic [DIV_N-1:0]     quo;
        logic [DIV_N:0]       rem;
    } div_rec_t;

    // Sign-corrected result as held in the output (and skid) register.
    typedef struct packed {
        logic                 vld;
        logic [DIV_TAG_W-1:0] tag;
        logic                 div0;
        logic                 ovf;
        logic [DIV_N-1:0]     q;
        logic [DIV_N-1:0]     r;
    } div_res_t;

    // Cycles from accept to result, counting the accept cycle.
    function automatic int div_latency(input int stages);
        return stages + 2;
    endfunction

    localparam logic [DIV_N-1:0] DIV0_Q = '1;
    localparam logic [DIV_N-1:0] OVF_Q  = {1'b1, {(DIV_N-1){1'b0}}};
    localparam logic [DIV_N-1:0] OVF_R  = '0;

endpackage

// File: rtl/div_stage.sv
// Combinational block of STEPS restoring division steps on one record.
module div_stage
    import div_pkg::*;
#(
    parameter int STEPS = 4
) (
    input  div_rec_t rec_i,
    output div_rec_t rec_o
);

    // Shift in one dividend bit, trial-subtract the divisor, keep on success.
    always_comb begin
        div_rec_t r;
        r = rec_i;
        for (int s = 0; s < STEPS; s++) begin
            r.rem = {r.rem[DIV_N-1:0], r.quo[DIV_N-1]};
            r.quo = {r.quo[DIV_N-2:0], 1'b0};
            if (r.rem >= {1'b0, r.dvs}) begin
                r.rem    = r.rem - {1'b0, r.dvs};
                r.quo[0] = 1'b1;
            end
        end
        rec_o = r;
    end

endmodule

// File: rtl/div_unit_pipelined_stream.sv
// Fully pipelined signed/unsigned restoring divider with valid/ready streaming.
// Entry register -> STAGES iteration registers -> output register.
// Optional macro DIVU_OUT_SKID_EN adds a one-entry output skid register so that
// in_ready comes straight from a flop and has no path from out_ready.
module div_unit_pipelined_stream
    import div_pkg::*;
#(
    parameter int N      = DIV_N,
    parameter int STAGES = DIV_STAGES,
    parameter int TAG_W  = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [N-1:0]     A_in,
    input  logic [N-1:0]     B_in,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     Q_out,
    output logic [N-1:0]     R_out,
    output logic             error_div0,
    output logic             overflow,
    output logic [TAG_W-1:0] out_tag
);

    localparam int STEPS = N / STAGES;

    function automatic logic [DIV_N-1:0] apply_sign(input logic [DIV_N-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    div_rec_t entry_d;
    div_rec_t stage_d   [STAGES+1];
    div_rec_t stage_q   [STAGES+1];
    div_rec_t stage_out [STAGES];
    div_res_t out_d, out_q, res;
    logic     en;
    logic     unused_bits;

    // Entry: take magnitudes, record result signs and special-case flags.
    always_comb begin
        logic neg_a, neg_b;
        neg_a         = in_signed & A_in[N-1];
        neg_b         = in_signed & B_in[N-1];
        entry_d       = '0;
        entry_d.vld   = in_valid & in_ready;
        entry_d.tag   = in_tag;
        entry_d.q_neg = neg_a ^ neg_b;
        entry_d.r_neg = neg_a;
        entry_d.div0  = (B_in == '0);
        entry_d.ovf   = in_signed && (A_in == OVF_Q) && (B_in == '1);
        entry_d.dvs   = apply_sign(B_in, neg_b);
        entry_d.quo   = apply_sign(A_in, neg_a);
        entry_d.rem   = '0;
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        div_stage #(.STEPS(STEPS)) u_stage (
            .rec_i (stage_q[g]),
            .rec_o (stage_out[g])
        );
    end

    // Next value of the entry register and of each iteration register.
    always_comb begin
        stage_d[0] = entry_d;
        for (int i = 1; i <= STAGES; i++) begin
            stage_d[i] = stage_out[i-1];
        end
    end

    // Entry and iteration registers; the whole pipe freezes when not enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '{default: '0};
        end else if (en) begin
            stage_q <= stage_d;
        end
    end

    // Output stage: sign correction, then div0/overflow overrides.
    always_comb begin
        div_rec_t s;
        s         = stage_q[STAGES];
        out_d.vld  = s.vld;
        out_d.tag  = s.tag;
        out_d.div0 = s.div0;
        out_d.ovf  = s.ovf;
        out_d.q    = apply_sign(s.quo, s.q_neg);
        out_d.r    = apply_sign(s.rem[DIV_N-1:0], s.r_neg);
        if (s.div0) begin
            out_d.q = DIV0_Q;
        end
        if (s.ovf) begin
            out_d.q = OVF_Q;
            out_d.r = OVF_R;
        end
    end

    assign unused_bits = ^{stage_q[STAGES].dvs, stage_q[STAGES].rem[DIV_N]};

    // Output register, cleared on reset so the result ports read zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else if (en) begin
            out_q <= out_d;
        end
    end

`ifdef DIVU_OUT_SKID_EN
    div_res_t skid_d, skid_q;
    logic     skid_full_d, skid_full_q;
    logic     in_ready_d, in_ready_q;

    // Skid parks the output-register result when the consumer refuses it.
    always_comb begin
        skid_full_d = skid_full_q ? !out_ready : (out_q.vld && !out_ready);
        skid_d      = skid_full_q ? skid_q : out_q;
        in_ready_d  = !skid_full_d;
    end

    // Skid register and registered in_ready (low through reset).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign en       = !skid_full_q;
    assign in_ready = in_ready_q;
    assign res      = skid_full_q ? skid_q : out_q;
`else
    logic alive_d, alive_q;

    // alive keeps in_ready low until the first edge after reset release.
    always_comb begin
        alive_d = 1'b1;
    end

    // Reset-release tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= alive_d;
        end
    end

    assign en       = !(out_q.vld && !out_ready);
    assign in_ready = alive_q && en;
    assign res      = out_q;
`endif

    assign out_valid  = res.vld;
    assign out_tag    = res.tag;
    assign Q_out      = res.q;
    assign R_out      = res.r;
    assign error_div0 = res.div0;
    assign overflow   = res.ovf;

endmodule

// File: tb/tb_div_unit_pipelined_stream.sv
// Directed self-checking bench for div_unit_pipelined_stream (N=16, STAGES=4).
module tb_div_unit_pipelined_stream;
    import div_pkg::*;

    typedef struct {
        bit          sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [15:0] q;
        logic [15:0] r;
        bit          dz;
        bit          ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [15:0] A_in = '0;
    logic [15:0] B_in = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] Q_out;
    logic [15:0] R_out;
    logic        error_div0;
    logic        overflow;
    logic [3:0]  out_tag;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t mon_v;
    vec_t stream_v[6];
    vec_t special_v[8];
    vec_t stall_v[8];

    div_unit_pipelined_stream #(.N(16), .STAGES(4), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .A_in       (A_in),
        .B_in       (B_in),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Q_out      (Q_out),
        .R_out      (R_out),
        .error_div0 (error_div0),
        .overflow   (overflow),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit s, logic [15:0] a, logic [15:0] b, logic [3:0] t,
                                logic [15:0] q, logic [15:0] r, bit dz, bit ov);
        vec_t v;
        v.sgn = s; v.a = a; v.b = b; v.tag = t; v.q = q; v.r = r; v.dz = dz; v.ov = ov;
        return v;
    endfunction

    // Present one op and hold it until accepted; returns 1 time unit after the accept edge.
    task automatic issue(input vec_t v);
        int n;
        bit acc;
        in_valid = 1'b1; in_signed = v.sgn; A_in = v.a; B_in = v.b; in_tag = v.tag;
        n = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        #1;
        if (acc) exp_q.push_back(v);
        else check_eq("accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_latency(input vec_t v);
        issue(v);
        check_eq("lat_edge0", {31'd0, out_valid}, 32'd0);
        for (int k = 1; k < div_latency(4) - 1; k++) begin
            @(posedge clk); #1;
            check_eq("lat_pre", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        check_eq("lat_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain", exp_q.size(), 32'd0);
    endtask

    // Scoreboard: every output transfer must match the oldest accepted op.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_v = exp_q.pop_front();
                check_eq("q", {16'd0, Q_out}, {16'd0, mon_v.q});
                check_eq("r", {16'd0, R_out}, {16'd0, mon_v.r});
                check_eq("div0", {31'd0, error_div0}, {31'd0, mon_v.dz});
                check_eq("ovf", {31'd0, overflow}, {31'd0, mon_v.ov});
                check_eq("tag", {28'd0, out_tag}, {28'd0, mon_v.tag});
            end
        end
`ifndef DIVU_OUT_SKID_EN
        if (rst && out_valid && !out_ready) begin
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
`endif
    end

`ifdef DIVU_OUT_SKID_EN
    logic rdy_after_edge;
    // in_ready must not move between edges when it comes from a flop.
    always begin
        @(posedge clk); #1;
        rdy_after_edge = in_ready;
        @(negedge clk);
        if (rst) check_eq("skid_rdy_flop", {31'd0, in_ready}, {31'd0, rdy_after_edge});
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        stream_v[0] = mk(1, 16'hFFB5, 16'd5,   4'd2, 16'hFFF1, 16'd0,    0, 0);
        stream_v[1] = mk(1, 16'd50,   16'hFFF6, 4'd3, 16'hFFFB, 16'd0,   0, 0);
        stream_v[2] = mk(1, 16'd22,   16'd5,   4'd4, 16'd4,    16'd2,    0, 0);
        stream_v[3] = mk(1, 16'hFFEA, 16'd5,   4'd5, 16'hFFFC, 16'hFFFE, 0, 0);
        stream_v[4] = mk(1, 16'd19,   16'd4,   4'd6, 16'd4,    16'd3,    0, 0);
        stream_v[5] = mk(1, 16'd5,    16'd10,  4'd7, 16'd0,    16'd5,    0, 0);

        special_v[0] = mk(1, 16'd25,   16'd0,    4'd8,  16'hFFFF, 16'd25,   1, 0);
        special_v[1] = mk(1, 16'h8000, 16'hFFFF, 4'd9,  16'h8000, 16'd0,    0, 1);
        special_v[2] = mk(1, 16'h8000, 16'd2,    4'd10, 16'hC000, 16'd0,    0, 0);
        special_v[3] = mk(1, 16'h7FFF, 16'd2,    4'd11, 16'h3FFF, 16'd1,    0, 0);
        special_v[4] = mk(0, 16'hFFFF, 16'd2,    4'd12, 16'h7FFF, 16'd1,    0, 0);
        special_v[5] = mk(0, 16'h8000, 16'hFFFF, 4'd13, 16'd0,    16'h8000, 0, 0);
        special_v[6] = mk(0, 16'd5,    16'd0,    4'd14, 16'hFFFF, 16'd5,    1, 0);
        special_v[7] = mk(1, 16'hFFF9, 16'd0,    4'd15, 16'hFFFF, 16'hFFF9, 1, 0);

        stall_v[0] = mk(0, 16'd10,   16'd3,   4'd0, 16'd3,    16'd1,    0, 0);
        stall_v[1] = mk(0, 16'd11,   16'd3,   4'd1, 16'd3,    16'd2,    0, 0);
        stall_v[2] = mk(0, 16'd12,   16'd3,   4'd2, 16'd4,    16'd0,    0, 0);
        stall_v[3] = mk(0, 16'd13,   16'd3,   4'd3, 16'd4,    16'd1,    0, 0);
        stall_v[4] = mk(0, 16'd100,  16'd7,   4'd4, 16'd14,   16'd2,    0, 0);
        stall_v[5] = mk(0, 16'd200,  16'd9,   4'd5, 16'd22,   16'd2,    0, 0);
        stall_v[6] = mk(0, 16'hFFFF, 16'd255, 4'd6, 16'h0101, 16'd0,    0, 0);
        stall_v[7] = mk(1, 16'hFF9C, 16'd7,   4'd7, 16'hFFF2, 16'hFFFE, 0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_q", {16'd0, Q_out}, 32'd0);
        check_eq("rst_r", {16'd0, R_out}, 32'd0);
        check_eq("rst_div0", {31'd0, error_div0}, 32'd0);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rst_tag", {28'd0, out_tag}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Latency with 100/5.
        run_latency(mk(1, 16'd100, 16'd5, 4'd1, 16'd20, 16'd0, 0, 0));
        wait_drain();

        // Back-to-back signed stream.
        for (int i = 0; i < 6; i++) issue(stream_v[i]);
        wait_drain();

        // Special cases and unsigned mode.
        for (int i = 0; i < 8; i++) issue(special_v[i]);
        wait_drain();

        // Backpressure mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) issue(stall_v[i]);
            end
            begin
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with operations in flight.
        for (int i = 0; i < 6; i++) issue(stream_v[i]);
        check_eq("prerst_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_q", {16'd0, Q_out}, 32'd0);
        check_eq("mid_rst_r", {16'd0, R_out}, 32'd0);
        check_eq("mid_rst_tag", {28'd0, out_tag}, 32'd0);
        check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("in_ready_after_rst2", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check_eq("no_stale_valid", {31'd0, out_valid}, 32'd0);
        end
        run_latency(mk(0, 16'd7, 16'd2, 4'd3, 16'd3, 16'd1, 0, 0));
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
